// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state codes, parity and line-level constants, counter width helper.
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_BREAK  = 3'd5;

  localparam logic PAR_EVEN   = 1'b0;
  localparam logic PAR_ODD    = 1'b1;
  localparam logic IDLE_LEVEL = 1'b1;

  // Counter width for values 0..n-1, never narrower than one bit.
  function automatic int uart_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: bit_done pulses in the last clk of each CLKS_PER_BIT period; clr holds it at 0.
// Zero latency from clr release to counting; no backpressure.
module uart_bit_timer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic bit_done
);

  localparam int PW = uart_width(CLKS_PER_BIT);
  localparam logic [PW-1:0] LAST = PW'(CLKS_PER_BIT - 1);

  logic [PW-1:0] cnt_q, cnt_d;

  assign bit_done = !clr && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || bit_done) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start, DATA_WIDTH bits LSB first, optional parity, STOP_BITS stops; tx_out falls on the accepting edge.
// data_ready only in IDLE or the last stop clk (back-to-back frames); optional line break under UART_TX_BREAK_EN.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] p_data,
  input  logic                  data_valid,
  output logic                  data_ready,
  input  logic                  par_en,
  input  logic                  par_typ,
`ifdef UART_TX_BREAK_EN
  input  logic                  send_break,
`endif
  output logic                  tx_out,
  output logic                  busy
);

  if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_data_width
    $error("uart_tx_param: DATA_WIDTH must be 5..9");
  end
  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_tx_param: CLKS_PER_BIT must be >= 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end

  localparam int BW = uart_width(DATA_WIDTH);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_WIDTH - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  logic [2:0]            state_q, state_d;
  logic [BW-1:0]         bit_q, bit_d;
  logic [DATA_WIDTH-1:0] dat_q, dat_d;
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;
  logic                  tx_q, tx_d;
  logic                  bit_done;
  logic                  frame_end;
  logic                  break_req;
  logic                  accept;

  uart_bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (state_q == ST_IDLE),
    .bit_done (bit_done)
  );

`ifdef UART_TX_BREAK_EN
  localparam int KW = uart_width(DATA_WIDTH + 3);
  localparam logic [KW-1:0] BRK_LAST = KW'(DATA_WIDTH + 2);

  logic [KW-1:0] brk_cnt_q, brk_cnt_d;
  logic          brk_hi_q, brk_hi_d;
  logic          brk_pend_q, brk_pend_d;

  // A request seen mid-frame is remembered and served at the frame boundary.
  assign break_req = send_break || brk_pend_q;
`else
  assign break_req = 1'b0;
`endif

  assign frame_end  = (state_q == ST_STOP) && bit_done && (bit_q == LAST_STOP);
  assign data_ready = ((state_q == ST_IDLE) || frame_end) && !break_req;
  assign accept     = data_valid && data_ready;
  assign tx_out     = tx_q;
  assign busy       = (state_q != ST_IDLE);

  always_comb begin
    state_d   = state_q;
    bit_d     = bit_q;
    dat_d     = dat_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    tx_d      = tx_q;
`ifdef UART_TX_BREAK_EN
    brk_cnt_d  = brk_cnt_q;
    brk_hi_d   = brk_hi_q;
    brk_pend_d = brk_pend_q ||
                 (send_break && (state_q != ST_IDLE) && (state_q != ST_BREAK));
`endif
    if (accept) begin
      state_d   = ST_START;
      tx_d      = 1'b0;
      bit_d     = '0;
      dat_d     = p_data;
      par_en_d  = par_en;
      par_bit_d = (^p_data) ^ par_typ;
    end else begin
      case (state_q)
        ST_IDLE: begin
`ifdef UART_TX_BREAK_EN
          if (break_req) begin
            state_d    = ST_BREAK;
            tx_d       = 1'b0;
            brk_cnt_d  = '0;
            brk_hi_d   = 1'b0;
            brk_pend_d = 1'b0;
          end
`endif
        end
        ST_START: begin
          if (bit_done) begin
            state_d = ST_DATA;
            tx_d    = dat_q[0];
            dat_d   = dat_q >> 1;
            bit_d   = '0;
          end
        end
        ST_DATA: begin
          if (bit_done) begin
            if (bit_q == LAST_DATA) begin
              bit_d = '0;
              if (par_en_q) begin
                state_d = ST_PARITY;
                tx_d    = par_bit_q;
              end else begin
                state_d = ST_STOP;
                tx_d    = IDLE_LEVEL;
              end
            end else begin
              bit_d = bit_q + 1'b1;
              tx_d  = dat_q[0];
              dat_d = dat_q >> 1;
            end
          end
        end
        ST_PARITY: begin
          if (bit_done) begin
            state_d = ST_STOP;
            tx_d    = IDLE_LEVEL;
            bit_d   = '0;
          end
        end
        ST_STOP: begin
          if (bit_done) begin
            if (bit_q == LAST_STOP) begin
              state_d = ST_IDLE;
              tx_d    = IDLE_LEVEL;
              bit_d   = '0;
`ifdef UART_TX_BREAK_EN
              if (break_req) begin
                state_d    = ST_BREAK;
                tx_d       = 1'b0;
                brk_cnt_d  = '0;
                brk_hi_d   = 1'b0;
                brk_pend_d = 1'b0;
              end
`endif
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end
        end
`ifdef UART_TX_BREAK_EN
        ST_BREAK: begin
          // Low for at least DATA_WIDTH+3 periods, then one high period before IDLE.
          if (bit_done) begin
            if (brk_hi_q) begin
              state_d  = ST_IDLE;
              brk_hi_d = 1'b0;
            end else if (brk_cnt_q == BRK_LAST) begin
              if (!send_break) begin
                tx_d     = IDLE_LEVEL;
                brk_hi_d = 1'b1;
              end
            end else begin
              brk_cnt_d = brk_cnt_q + 1'b1;
            end
          end
        end
`endif
        default: begin
          state_d = ST_IDLE;
          tx_d    = IDLE_LEVEL;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      bit_q     <= '0;
      dat_q     <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      tx_q      <= IDLE_LEVEL;
    end else begin
      state_q   <= state_d;
      bit_q     <= bit_d;
      dat_q     <= dat_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      tx_q      <= tx_d;
    end
  end

`ifdef UART_TX_BREAK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      brk_cnt_q  <= '0;
      brk_hi_q   <= 1'b0;
      brk_pend_q <= 1'b0;
    end else begin
      brk_cnt_q  <= brk_cnt_d;
      brk_hi_q   <= brk_hi_d;
      brk_pend_q <= brk_pend_d;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench for uart_tx_param: table-driven frames through a scoreboard plus hand-written corner sequences.
module tb_uart_tx_param;

  localparam int CPB = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] p_data;
  logic       data_valid, data_ready, par_en, par_typ, tx_out, busy;
  logic [6:0] d2_data;
  logic       d2_valid, d2_ready, d2_tx, d2_busy;
`ifdef UART_TX_BREAK_EN
  logic       send_break;
  logic       d2_break;
`endif

  uart_tx_param #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .p_data     (p_data),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .par_en     (par_en),
    .par_typ    (par_typ),
`ifdef UART_TX_BREAK_EN
    .send_break (send_break),
`endif
    .tx_out     (tx_out),
    .busy       (busy)
  );

  uart_tx_param #(.DATA_WIDTH(7), .CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut2 (
    .clk        (clk),
    .rst        (rst),
    .p_data     (d2_data),
    .data_valid (d2_valid),
    .data_ready (d2_ready),
    .par_en     (1'b0),
    .par_typ    (1'b0),
`ifdef UART_TX_BREAK_EN
    .send_break (d2_break),
`endif
    .tx_out     (d2_tx),
    .busy       (d2_busy)
  );

  typedef struct {
    logic [7:0] data;
    logic       pe;
    logic       pt;
    logic       exp_par;
    int         exp_cycles;
  } vec_t;

  typedef struct {
    logic [7:0] data;
    logic       pe;
    logic       exp_par;
    int         exp_cycles;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Bit levels of one frame, first bit at index 0; unused upper bits stay high (stop level).
  function automatic logic [15:0] frame_bits(input logic [8:0] d, input int dw, input logic pe,
                                             input logic par, input int sb, output int n);
    logic [15:0] b;
    b = '1;
    n = 0;
    b[n] = 1'b0;
    n++;
    for (int i = 0; i < dw; i++) begin
      b[n] = d[i];
      n++;
    end
    if (pe) begin
      b[n] = par;
      n++;
    end
    n += sb;
    return b;
  endfunction

  // Scoreboard monitor for dut: pops one expectation per observed start bit.
  int          mon_t   = 0;
  int          mon_len = 0;
  int          mon_nb;
  logic [15:0] mon_bits;
  logic        mon_bad;
  logic        mon_post = 1'b0;
  bit          mon_en   = 1'b1;
  exp_t        cur;

  always @(negedge clk) begin
    if (rst) begin
      mon_len  = 0;
      mon_post = 1'b0;
    end else if (mon_en) begin
      if (mon_len == 0) begin
        if (mon_post) begin
          mon_post = 1'b0;
          if (sb_q.size() == 0) chk("idle_after_frame", 64'({tx_out, busy}), 64'b10);
          else                  chk("back_to_back_start", 64'({tx_out, busy}), 64'b01);
        end
        if (tx_out === 1'b0) begin
          if (sb_q.size() == 0) begin
            chk("unexpected_start", 64'(tx_out), 64'd1);
          end else begin
            cur      = sb_q.pop_front();
            mon_bits = frame_bits({1'b0, cur.data}, 8, cur.pe, cur.exp_par, 1, mon_nb);
            mon_len  = cur.exp_cycles;
            mon_t    = 0;
            mon_bad  = 1'b0;
          end
        end
      end
      if (mon_len != 0) begin
        if (tx_out !== mon_bits[mon_t / CPB] || busy !== 1'b1) mon_bad = 1'b1;
        mon_t++;
        if (mon_t == mon_len) begin
          chk($sformatf("frame_wave_%02h", cur.data), 64'(mon_bad), 64'd0);
          mon_len  = 0;
          mon_post = 1'b1;
        end
      end
    end
  end

  task automatic send_word(input logic [7:0] d, input logic pe, input logic pt,
                           input logic exp_par, input int cyc, input bit keep);
    exp_t e;
    int   w;
    p_data     = d;
    par_en     = pe;
    par_typ    = pt;
    data_valid = 1'b1;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (data_ready !== 1'b1 && w < 400);
    if (data_ready !== 1'b1) begin
      chk("ready_timeout", 64'(data_ready), 64'd1);
      data_valid = 1'b0;
      return;
    end
    @(posedge clk);
    e.data = d;
    e.pe = pe;
    e.exp_par = exp_par;
    e.exp_cycles = cyc;
    sb_q.push_back(e);
    #1;
    if (!keep) begin
      data_valid = 1'b0;
      p_data     = 8'($urandom);
      par_en     = 1'($urandom);
      par_typ    = 1'($urandom);
    end
  endtask

  task automatic wait_idle();
    int w;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while ((busy !== 1'b0 || mon_len != 0 || sb_q.size() != 0 || mon_post) && w < 1000);
    if (w >= 1000) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: busy=%0b pending=%0d", busy, sb_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[6];
    logic [9:0]  seq;
    logic [39:0] cap, expw;
    logic [79:0] cap2;
    logic [15:0] fb;
    int          nb, busycnt, rdyb, falls, acc, w;
    logic        prev_busy;

    rst = 1'b1; p_data = '0; data_valid = 1'b0; par_en = 1'b0; par_typ = 1'b0;
    d2_data = '0; d2_valid = 1'b0;
`ifdef UART_TX_BREAK_EN
    send_break = 1'b0;
    d2_break   = 1'b0;
`endif
    vecs[0] = '{8'hA5, 1'b0, 1'b0, 1'b0, 40};
    vecs[1] = '{8'hA5, 1'b1, 1'b0, 1'b0, 44};
    vecs[2] = '{8'hA5, 1'b1, 1'b1, 1'b1, 44};
    vecs[3] = '{8'h3C, 1'b1, 1'b1, 1'b1, 44};
    vecs[4] = '{8'h01, 1'b1, 1'b0, 1'b1, 44};
    vecs[5] = '{8'hFE, 1'b1, 1'b1, 1'b0, 44};

    repeat (2) @(posedge clk);
    #1;
    chk("rst_tx", 64'(tx_out), 64'd1);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ready", 64'(data_ready), 64'd1);
    chk("rst_d2_tx", 64'(d2_tx), 64'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Literal waveform of 0xA5 without parity.
    seq = 10'b1101001010;
    for (int i = 0; i < 40; i++) expw[i] = seq[i / CPB];
    send_word(8'hA5, 1'b0, 1'b0, 1'b0, 40, 1'b0);
    busycnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      cap[i] = tx_out;
      busycnt += int'(busy);
    end
    chk("t1_wave", 64'(cap), 64'(expw));
    chk("t1_busy_cycles", 64'(busycnt), 64'd40);
    wait_idle();

    for (int v = 0; v < 6; v++) begin
      send_word(vecs[v].data, vecs[v].pe, vecs[v].pt, vecs[v].exp_par, vecs[v].exp_cycles, 1'b0);
      wait_idle();
    end

    // Three words with valid held: contiguous frames, ready only in last stop clk.
    busycnt = 0; rdyb = 0; falls = 0; prev_busy = 1'b0;
    fork
      begin
        send_word(8'h00, 1'b0, 1'b0, 1'b0, 40, 1'b1);
        send_word(8'hFF, 1'b0, 1'b0, 1'b0, 40, 1'b1);
        send_word(8'h3C, 1'b0, 1'b0, 1'b0, 40, 1'b0);
      end
      begin
        for (int i = 0; i < 130; i++) begin
          @(negedge clk);
          busycnt += int'(busy);
          rdyb    += int'(busy && data_ready);
          if (prev_busy && !busy) falls++;
          prev_busy = busy;
        end
      end
    join
    chk("t3_busy_cycles", 64'(busycnt), 64'd120);
    chk("t3_ready_pulses", 64'(rdyb), 64'd3);
    chk("t3_busy_falls", 64'(falls), 64'd1);
    wait_idle();

    // dut2: 7 data bits, 2 stop bits, second word offered mid-frame.
    d2_data  = 7'h55;
    d2_valid = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    d2_valid = 1'b0;
    d2_data  = 7'h00;
    acc = -1; busycnt = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      cap2[i] = d2_tx;
      busycnt += int'(d2_busy);
      if (acc >= 0 && i == acc + 1) d2_valid = 1'b0;
      if (d2_valid && d2_ready && acc < 0) acc = i;
      if (i == 10) begin
        d2_data  = 7'h2A;
        d2_valid = 1'b1;
      end
    end
    fb = frame_bits({2'b00, 7'h55}, 7, 1'b0, 1'b0, 2, nb);
    for (int i = 0; i < 40; i++) expw[i] = fb[i / CPB];
    chk("t4_frame1", 64'(cap2[39:0]), 64'(expw));
    chk("t4_stop_high", 64'(cap2[39:32]), 64'hFF);
    fb = frame_bits({2'b00, 7'h2A}, 7, 1'b0, 1'b0, 2, nb);
    for (int i = 0; i < 40; i++) expw[i] = fb[i / CPB];
    chk("t4_frame2", 64'(cap2[79:40]), 64'(expw));
    chk("t4_accept_cycle", 64'(acc), 64'd39);
    chk("t4_busy_cycles", 64'(busycnt), 64'd80);
    d2_valid = 1'b0;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (d2_busy !== 1'b0 && w < 200);
    chk("t4_idle_after", 64'({d2_tx, d2_busy}), 64'b10);
    @(posedge clk);
    #1;

    // Reset in the middle of data bit 3 (0x52 has bit 3 low).
    send_word(8'h52, 1'b0, 1'b0, 1'b0, 40, 1'b0);
    repeat (17) @(posedge clk);
    #1;
    chk("t5_bit3_low", 64'(tx_out), 64'd0);
    rst = 1'b1;
    data_valid = 1'b1;
    p_data = 8'hFF;
    #1;
    chk("t5_rst_tx", 64'(tx_out), 64'd1);
    chk("t5_rst_busy", 64'(busy), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("t5_no_accept_in_rst", 64'({tx_out, busy}), 64'b10);
    rst = 1'b0;
    data_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("t5_idle_after_rst", 64'({tx_out, busy}), 64'b10);
    send_word(8'h81, 1'b0, 1'b0, 1'b0, 40, 1'b0);
    wait_idle();

`ifdef UART_TX_BREAK_EN
    mon_en = 1'b0;
    send_break = 1'b1;
    @(posedge clk);
    #1;
    send_break = 1'b0;
    nb = 0; busycnt = 0; rdyb = 0; w = 0;
    for (int i = 0; i < 48; i++) begin
      @(negedge clk);
      if (i < 44) nb += int'(tx_out == 1'b0);
      else        w  += int'(tx_out == 1'b1);
      rdyb    += int'(data_ready);
      busycnt += int'(busy);
    end
    @(negedge clk);
    chk("t6_break_low", 64'(nb), 64'd44);
    chk("t6_break_high", 64'(w), 64'd4);
    chk("t6_ready_low", 64'(rdyb), 64'd0);
    chk("t6_busy", 64'(busycnt), 64'd48);
    chk("t6_idle_after", 64'({tx_out, busy}), 64'b10);
    @(posedge clk);
    #1;
    mon_en = 1'b1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
